instr_decode_stage: RTL and testbench

- Pipelined RV32I decode stage that sits between instruction fetch and the execute stage.
- Accepts one 32-bit instruction per valid/ready handshake.
- Produces the 17-bit ALU control word {funct7[16:10], funct3[9:7], opcode[6:0]} that the execute ALU consumes, plus register indices, the sign-extended immediate and control flags.
- A registered output with a one-entry skid buffer gives full throughput with no combinational ready path.

---
 rtl/instr_decode_stage_if.sv | 34 +++
 rtl/instr_decode_stage.sv | 178 +++++++++++++++++
 tb/tb_instr_decode_stage.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle.
// master drives instructions in, slave is the decode stage.
`timescale 1ns/1ps
interface instr_decode_stage_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [16:0]     alu_op;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [31:0]     imm;
  logic            use_imm;
  logic            reg_we;
  logic            illegal;
  logic [PC_W-1:0] out_pc;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, alu_op, rs1, rs2, rd,
    input  imm, use_imm, reg_we, illegal, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, alu_op, rs1, rs2, rd,
    output imm, use_imm, reg_we, illegal, out_pc
  );
endinterface

// File: rtl/instr_decode_stage.sv
// RV32I decode stage: comb decode into a registered output
// plus one skid entry, so in_ready never depends on out_ready.
`timescale 1ns/1ps
module instr_decode_stage #(
  parameter int PC_W       = 32,
  parameter bit RD_ZERO_WE = 1'b0
) (
  input logic                clk,
  input logic                rst,
  input logic                flush,
  instr_decode_stage_if.slave bus
);
  typedef struct packed {
    logic [16:0]     alu_op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic            use_imm;
    logic            reg_we;
    logic            illegal;
    logic [PC_W-1:0] pc;
  } bundle_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  logic [31:0] ins;
  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic        shift;
  logic        bad;
  bundle_t     dec;
  bundle_t     hold;
  bundle_t     skid;
  logic        out_valid;
  logic        skid_full;
  logic        free;
  logic        acc;

  assign ins   = bus.in_instr;
  assign opc   = ins[6:0];
  assign f7    = ins[31:25];
  assign f3    = ins[14:12];
  assign shift = f3[1:0] == 2'b01;

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'd0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12],
                  ins[20], ins[30:21], 1'b0};

  // decode the incoming word into a bundle; illegal words are scrubbed
  always_comb begin
    dec     = '0;
    bad     = 1'b0;
    dec.rs1 = ins[19:15];
    dec.rs2 = ins[24:20];
    dec.rd  = ins[11:7];
    dec.pc  = bus.in_pc;
    unique case (1'b1)
      opc == OP_R: begin
        dec.alu_op = {f7, f3, opc};
        dec.reg_we = 1'b1;
        bad = !(f7 == 7'd0 ||
               (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
      end
      opc == OP_I: begin
        dec.use_imm = 1'b1;
        dec.reg_we  = 1'b1;
        if (shift) begin
          // shifts reuse the R-type shifter with b taken from imm
          dec.alu_op = {f7, f3, OP_R};
          dec.imm    = {27'd0, ins[24:20]};
          bad = !(f7 == 7'd0 || (f3[2] && f7 == F7_ALT));
        end else begin
          dec.alu_op = {7'd0, f3, opc};
          dec.imm    = imm_i;
        end
      end
      opc == OP_LD, opc == OP_JR: begin
        dec.alu_op  = {7'd0, f3, opc};
        dec.imm     = imm_i;
        dec.use_imm = 1'b1;
        dec.reg_we  = 1'b1;
      end
      opc == OP_ST: begin
        dec.alu_op  = {7'd0, f3, opc};
        dec.imm     = imm_s;
        dec.use_imm = 1'b1;
      end
      opc == OP_BR: begin
        dec.alu_op = {7'd0, f3, opc};
        dec.imm    = imm_b;
      end
      opc == OP_LUI, opc == OP_AUI: begin
        dec.alu_op  = {7'd0, f3, opc};
        dec.imm     = imm_u;
        dec.use_imm = 1'b1;
        dec.reg_we  = 1'b1;
      end
      opc == OP_JAL: begin
        dec.alu_op  = {7'd0, f3, opc};
        dec.imm     = imm_j;
        dec.use_imm = 1'b1;
        dec.reg_we  = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (!RD_ZERO_WE && ins[11:7] == 5'd0) dec.reg_we = 1'b0;
    if (bad) begin
      dec.alu_op  = '0;
      dec.imm     = '0;
      dec.use_imm = 1'b0;
      dec.reg_we  = 1'b0;
    end
    dec.illegal = bad;
  end

  assign free = !out_valid || bus.out_ready;
  assign acc  = bus.in_valid && !skid_full;

  // occupancy of output register and skid entry
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
    end else if (free) begin
      out_valid <= skid_full || acc;
      skid_full <= 1'b0;
    end else if (acc) begin
      skid_full <= 1'b1;
    end
  end

  // bundle storage; skid drains first to keep FIFO order
  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
      skid <= '0;
    end else if (!flush) begin
      if (free) begin
        if (skid_full) hold <= skid;
        else if (acc)  hold <= dec;
      end else if (acc) begin
        skid <= dec;
      end
    end
  end

  assign bus.in_ready  = !skid_full;
  assign bus.out_valid = out_valid;
  assign bus.alu_op    = hold.alu_op;
  assign bus.rs1       = hold.rs1;
  assign bus.rs2       = hold.rs2;
  assign bus.rd        = hold.rd;
  assign bus.imm       = hold.imm;
  assign bus.use_imm   = hold.use_imm;
  assign bus.reg_we    = hold.reg_we;
  assign bus.illegal   = hold.illegal;
  assign bus.out_pc    = hold.pc;
endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: driver pushes model
// results on accept, negedge monitor pops on every output transfer.
`timescale 1ns/1ps
module tb_instr_decode_stage;
  localparam int PC_W = 32;
  localparam bit RZW  = 1'b0;

  typedef struct packed {
    logic [16:0]     alu;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic            use_imm;
    logic            reg_we;
    logic            illegal;
    logic [PC_W-1:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   total = 0;
  int   bad = 0;
  bit   rand_rdy = 1'b0;
  exp_t sb[$];

  instr_decode_stage_if #(.PC_W(PC_W)) bus();

  instr_decode_stage #(.PC_W(PC_W), .RD_ZERO_WE(RZW)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [127:0] act, logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t got();
    exp_t g;
    g = {bus.alu_op, bus.rs1, bus.rs2, bus.rd, bus.imm,
         bus.use_imm, bus.reg_we, bus.illegal, bus.out_pc};
    return g;
  endfunction

  // reference decode, from the ISA field rules with plain arithmetic
  function automatic exp_t model(logic [31:0] i, logic [31:0] pc);
    exp_t e;
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    bit ok;
    int v;
    op = i[6:0]; f7 = i[31:25]; f3 = i[14:12];
    ok = 1'b1; v = 0;
    e = '0;
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7]; e.pc = pc;
    case (op)
      7'h33: begin
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        e.alu = {f7, f3, op}; e.reg_we = 1;
      end
      7'h13: begin
        e.use_imm = 1; e.reg_we = 1;
        if (f3 == 1 || f3 == 5) begin
          ok = (f7 == 0) || (f3 == 5 && f7 == 7'h20);
          e.alu = {f7, f3, 7'h33};
          e.imm = 32'(i[24:20]);
        end else begin
          e.alu = {7'h0, f3, op};
          e.imm = 32'(int'($signed(i[31:20])));
        end
      end
      7'h03, 7'h67: begin
        e.alu = {7'h0, f3, op}; e.use_imm = 1; e.reg_we = 1;
        e.imm = 32'(int'($signed(i[31:20])));
      end
      7'h23: begin
        e.alu = {7'h0, f3, op}; e.use_imm = 1;
        v = int'($signed(i[31:25])) * 32 + int'(i[11:7]);
        e.imm = 32'(v);
      end
      7'h63: begin
        e.alu = {7'h0, f3, op};
        v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048
          + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        e.imm = 32'(v);
      end
      7'h37, 7'h17: begin
        e.alu = {7'h0, f3, op}; e.use_imm = 1; e.reg_we = 1;
        e.imm = i & 32'hFFFFF000;
      end
      7'h6F: begin
        e.alu = {7'h0, f3, op}; e.use_imm = 1; e.reg_we = 1;
        v = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096
          + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
        e.imm = 32'(v);
      end
      default: ok = 1'b0;
    endcase
    if (!RZW && e.rd == 0) e.reg_we = 0;
    if (!ok) begin
      e.alu = '0; e.imm = '0; e.use_imm = 0; e.reg_we = 0;
      e.illegal = 1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                           7'h37, 7'h17, 7'h6F, 7'h67};
    int k;
    r = $urandom;
    k = $urandom_range(0, 10);
    if (k < 9) r[6:0] = ops[k];
    if (r[6:0] == 7'h33 || r[6:0] == 7'h13) begin
      case ($urandom_range(0, 2))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        default: ;
      endcase
    end
    return r;
  endfunction

  // monitor: every output transfer must match the scoreboard head
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && !flush && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 128'(bus.out_pc), 128'hDEAD);
      end else begin
        e = sb.pop_front();
        chk("bundle", got(), e);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(logic [31:0] ins, logic [31:0] pc);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_instr = ins; bus.in_pc = pc;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(model(ins, pc));
        return;
      end
      @(posedge clk); #1;
    end
    chk("accept_timeout", 0, 1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // directed single instruction with hand-derived fields
  task automatic one(string name, logic [31:0] ins, logic [16:0] alu,
                     logic [31:0] imm, logic u, logic w, logic il);
    send(ins, 32'h100);
    idle();
    @(negedge clk);
    chk({name, "_valid"}, 128'(bus.out_valid), 1);
    chk(name, {bus.alu_op, bus.imm, bus.use_imm, bus.reg_we, bus.illegal},
        {alu, imm, u, w, il});
  endtask

  initial begin
    logic [31:0] pc;
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ctl", {bus.out_valid, bus.in_ready}, 2'b01);
    chk("reset_data", got(), 0);

    @(posedge clk); #1 bus.out_ready = 1'b1;
    one("add", 32'h002081B3, 17'b0000000_000_0110011, 0, 0, 1, 0);
    chk("add_regs", {bus.rs1, bus.rs2, bus.rd}, {5'd1, 5'd2, 5'd3});
    one("srai", 32'h40735293, 17'b0100000_101_0110011, 7, 1, 1, 0);
    one("addi", 32'hFFF00093, 17'b0000000_000_0010011,
        32'hFFFFFFFF, 1, 1, 0);
    one("beq", 32'hFE000EE3, 17'b0000000_000_1100011,
        32'hFFFFFFFC, 0, 0, 0);
    one("jal", 32'h004000EF, 17'b0000000_000_1101111, 4, 1, 1, 0);
    one("lui", 32'h12345037, 17'b0000000_101_0110111,
        32'h12345000, 1, 0, 0);
    one("add_x0", 32'h00208033, 17'b0000000_000_0110011, 0, 0, 0, 0);
    one("zero_word", 32'h00000000, 0, 0, 0, 0, 1);
    one("r_alt_bad", 32'h4020C1B3, 0, 0, 0, 0, 1);
    one("slli_ok", 32'h00309093, 17'b0000000_001_0110011, 3, 1, 1, 0);

    // stall: first held on output, second in skid
    @(posedge clk); #1 bus.out_ready = 1'b0;
    send(32'h00108093, 32'h200);
    send(32'h00210113, 32'h204);
    idle();
    @(negedge clk);
    chk("stall_ready", 128'(bus.in_ready), 0);
    chk("stall_hold", {bus.out_valid, bus.rd, bus.out_pc},
        {1'b1, 5'd1, 32'h200});
    @(posedge clk); #1 bus.out_ready = 1'b1;
    send(32'h00318193, 32'h208);
    idle();
    repeat (4) @(posedge clk);

    // flush with output held (k=1) and with skid full (k=2)
    for (int k = 1; k <= 2; k++) begin
      #1 bus.out_ready = 1'b0;
      for (int j = 0; j < k; j++) send(32'h00A00513, 32'h300 + 4 * j);
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.in_instr = 32'h00B00593;
      bus.in_pc = 32'h3F0; flush = 1'b1;
      sb.delete();
      @(posedge clk); #1;
      flush = 1'b0; bus.in_valid = 1'b0;
      @(negedge clk);
      chk("flush_ctl", {bus.out_valid, bus.in_ready}, 2'b01);
      @(posedge clk); #1 bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
    end

    // reset while stalled with skid full
    #1 bus.out_ready = 1'b0;
    send(32'h00C00613, 32'h400);
    send(32'h00D00693, 32'h404);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; rst = 1'b1;
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ctl", {bus.out_valid, bus.in_ready}, 2'b01);
    chk("rst_mid_data", got(), 0);

    // random stream against the model with random backpressure
    rand_rdy = 1'b1;
    pc = 32'h1000;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) idle();
      send(rand_instr(), pc);
      pc += 4;
    end
    idle();
    rand_rdy = 1'b0;
    @(posedge clk); #1 bus.out_ready = 1'b1;
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
    chk("drain", 128'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
